carp_bol_birimi: RTL

//  Parametrised, iterative RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/carp_bol_birimi_pkg.sv | 37 +++
 rtl/carp_bol_birimi_if.sv | 25 ++
 rtl/carp_bol_adim.sv | 30 +++
 rtl/carp_bol_birimi.sv | 134 +++++++++++++
 4 files changed

// File: rtl/carp_bol_birimi_pkg.sv
// Shared types for the iterative M-extension unit: op select (funct3 order),
// FSM state encoding and small op-decode helpers.
package carp_bol_birimi_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } islem_e;

   typedef enum logic [2:0] {
      CB_BOSTA   = 3'd0,
      CB_HAZIRLA = 3'd1,
      CB_HESAPLA = 3'd2,
      CB_DUZELT  = 3'd3,
      CB_SONUC   = 3'd4
   } durum_e;

   // MUL keeps its operands unsigned: the low half of the product is sign-agnostic.
   function automatic logic isaretli1(islem_e op);
      return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   endfunction

   function automatic logic isaretli2(islem_e op);
      return op inside {MD_MULH, MD_DIV, MD_REM};
   endfunction

   function automatic logic kalan_mi(islem_e op);
      return op inside {MD_REM, MD_REMU};
   endfunction

endpackage

// File: rtl/carp_bol_birimi_if.sv
// Request/result handshake bundle of the multiply/divide unit.
interface carp_bol_birimi_if #(
   parameter int VERI_BIT = 32
);
   logic                istek_gecerli_i;
   logic                istek_hazir_o;
   logic [2:0]          islem_i;
   logic [VERI_BIT-1:0] deger1_i;
   logic [VERI_BIT-1:0] deger2_i;
   logic                iptal_i;
   logic                sonuc_gecerli_o;
   logic                sonuc_hazir_i;
   logic [VERI_BIT-1:0] sonuc_o;
   logic                mesgul_o;

   modport slave (
      input  istek_gecerli_i, islem_i, deger1_i, deger2_i, iptal_i, sonuc_hazir_i,
      output istek_hazir_o, sonuc_gecerli_o, sonuc_o, mesgul_o
   );

   modport master (
      output istek_gecerli_i, islem_i, deger1_i, deger2_i, iptal_i, sonuc_hazir_i,
      input  istek_hazir_o, sonuc_gecerli_o, sonuc_o, mesgul_o
   );
endinterface

// File: rtl/carp_bol_adim.sv
// One iteration of the unit: shift-add multiply step or restoring
// shift-subtract divide step over the {ust, alt} accumulator pair.
module carp_bol_adim #(
   parameter int VERI_BIT = 32
) (
   input  logic                bolme_i,
   input  logic [VERI_BIT-1:0] ust_i,
   input  logic [VERI_BIT-1:0] alt_i,
   input  logic [VERI_BIT-1:0] carpan_i,
   output logic [VERI_BIT-1:0] ust_o,
   output logic [VERI_BIT-1:0] alt_o
);
   logic [VERI_BIT:0] toplam;
   logic [VERI_BIT:0] kayik;
   logic              sigar;

   always_comb begin
      toplam = {1'b0, ust_i} + (alt_i[0] ? {1'b0, carpan_i} : '0);
      kayik  = {ust_i, alt_i[VERI_BIT-1]};
      sigar  = kayik >= {1'b0, carpan_i};
      if (bolme_i) begin
         // Partial remainder stays below the divisor, so N-bit wraparound is exact.
         ust_o = sigar ? (kayik[VERI_BIT-1:0] - carpan_i) : kayik[VERI_BIT-1:0];
         alt_o = {alt_i[VERI_BIT-2:0], sigar};
      end else begin
         ust_o = toplam[VERI_BIT:1];
         alt_o = {toplam[0], alt_i[VERI_BIT-1:1]};
      end
   end
endmodule

// File: rtl/carp_bol_birimi.sv
// Iterative RISC-V M-extension unit (MUL*/DIV*/REM*): FSM, counter, sign fix-up.
// Optional HIZLI_CARPMA_EN: single-cycle combinational multiply in HAZIRLA.
module carp_bol_birimi
   import carp_bol_birimi_pkg::*;
#(
   parameter int VERI_BIT  = 32,
   parameter int SAYAC_BIT = 6
) (
   input logic               clk_i,
   input logic               rst_i,
   carp_bol_birimi_if.slave  bus
);
   localparam logic [VERI_BIT-1:0] EN_KUCUK = {1'b1, {(VERI_BIT-1){1'b0}}};

   durum_e                durum_q, durum_d;
   islem_e                islem_q;
   logic [VERI_BIT-1:0]   ust_q, alt_q, b_q, sonuc_q;
   logic                  neg_q;
   logic [SAYAC_BIT-1:0]  sayac_q;

   logic                  kabul, bolme, isr1, isr2, neg_d, sifir_bolen, tasma, ozel;
   logic [VERI_BIT-1:0]   mutlak1, mutlak2, ozel_sonuc, ust_adim, alt_adim, bol_secim, duz_sonuc;
   logic [2*VERI_BIT-1:0] carpim_s;

   assign kabul = bus.istek_gecerli_i && (durum_q == CB_BOSTA) && !bus.iptal_i;
   assign bolme = islem_q[2];

   // In HAZIRLA alt_q/b_q still hold the raw rs1/rs2 captured at accept.
   always_comb begin
      isr1        = isaretli1(islem_q) && alt_q[VERI_BIT-1];
      isr2        = isaretli2(islem_q) && b_q[VERI_BIT-1];
      mutlak1     = isr1 ? -alt_q : alt_q;
      mutlak2     = isr2 ? -b_q : b_q;
      neg_d       = kalan_mi(islem_q) ? isr1 : (isr1 ^ isr2);
      sifir_bolen = bolme && (b_q == '0);
      tasma       = (islem_q inside {MD_DIV, MD_REM}) && (alt_q == EN_KUCUK) && (&b_q);
      ozel        = sifir_bolen || tasma;
      if (sifir_bolen) ozel_sonuc = kalan_mi(islem_q) ? alt_q : '1;
      else             ozel_sonuc = kalan_mi(islem_q) ? '0 : alt_q;
   end

   carp_bol_adim #(.VERI_BIT(VERI_BIT)) u_adim (
      .bolme_i  (bolme),
      .ust_i    (ust_q),
      .alt_i    (alt_q),
      .carpan_i (b_q),
      .ust_o    (ust_adim),
      .alt_o    (alt_adim)
   );

   always_comb begin
      carpim_s  = neg_q ? -{ust_q, alt_q} : {ust_q, alt_q};
      bol_secim = kalan_mi(islem_q) ? ust_q : alt_q;
      if (bolme)                 duz_sonuc = neg_q ? -bol_secim : bol_secim;
      else if (islem_q == MD_MUL) duz_sonuc = carpim_s[VERI_BIT-1:0];
      else                       duz_sonuc = carpim_s[2*VERI_BIT-1:VERI_BIT];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) durum_q <= CB_BOSTA;
      else       durum_q <= durum_d;
   end

   always_comb begin
      durum_d = durum_q;
      case (durum_q)
         CB_BOSTA:   if (kabul) durum_d = CB_HAZIRLA;
         CB_HAZIRLA: begin
            if (ozel) durum_d = CB_SONUC;
`ifdef HIZLI_CARPMA_EN
            else if (!bolme) durum_d = CB_DUZELT;
`endif
            else durum_d = CB_HESAPLA;
         end
         CB_HESAPLA: if (sayac_q == SAYAC_BIT'(VERI_BIT-1)) durum_d = CB_DUZELT;
         CB_DUZELT:  durum_d = CB_SONUC;
         CB_SONUC:   if (bus.sonuc_hazir_i) durum_d = CB_BOSTA;
         default:    durum_d = CB_BOSTA;
      endcase
      // Flush beats everything, including a result handshake on the same edge.
      if (bus.iptal_i && (durum_q != CB_BOSTA)) durum_d = CB_BOSTA;
   end

   always_comb begin
      bus.istek_hazir_o   = (durum_q == CB_BOSTA);
      bus.sonuc_gecerli_o = (durum_q == CB_SONUC);
      bus.mesgul_o        = (durum_q != CB_BOSTA);
   end

   assign bus.sonuc_o = sonuc_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         islem_q <= MD_MUL;
         ust_q   <= '0;
         alt_q   <= '0;
         b_q     <= '0;
         sonuc_q <= '0;
         neg_q   <= 1'b0;
         sayac_q <= '0;
      end else begin
         case (durum_q)
            CB_BOSTA: if (kabul) begin
               islem_q <= islem_e'(bus.islem_i);
               alt_q   <= bus.deger1_i;
               b_q     <= bus.deger2_i;
            end
            CB_HAZIRLA: begin
               neg_q   <= neg_d;
               sayac_q <= '0;
               b_q     <= mutlak2;
               if (ozel) sonuc_q <= ozel_sonuc;
`ifdef HIZLI_CARPMA_EN
               if (!bolme) {ust_q, alt_q} <= mutlak1 * mutlak2;
               else begin
                  ust_q <= '0;
                  alt_q <= mutlak1;
               end
`else
               ust_q <= '0;
               alt_q <= mutlak1;
`endif
            end
            CB_HESAPLA: begin
               ust_q   <= ust_adim;
               alt_q   <= alt_adim;
               sayac_q <= sayac_q + 1'b1;
            end
            CB_DUZELT: sonuc_q <= duz_sonuc;
            default: ;
         endcase
      end
   end
endmodule
